// File: rtl/serial_subtractor.sv
// Multi-cycle saturating two's-complement subtractor: Diff = A + ~B + 1,
// evaluated DIGIT bits per cycle from LSB to MSB, with N/Z/V flags.
module serial_subtractor #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             FlagN,
    output logic             FlagZ,
    output logic             FlagV,
    output logic [1:0]       o_dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; in_ready is high only in IDLE, out_valid only in DONE, and
    // Diff/flags stay constant while out_valid is high until out_ready is seen.

    // WIDTH must be a multiple of DIGIT; K is the number of RUN cycles.
    localparam int K  = WIDTH / DIGIT;
    localparam int CW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic [CW-1:0]    r_count;
    logic             r_sign_a;
    logic             r_sign_nb;
    logic [WIDTH-1:0] r_diff;
    logic             r_flag_n;
    logic             r_flag_z;
    logic             r_flag_v;

    logic [DIGIT:0]   w_chain;
    logic [DIGIT-1:0] w_sum;
    logic [WIDTH-1:0] w_res_next;
    logic [WIDTH-1:0] w_sat;
    logic [WIDTH-1:0] w_final;
    logic             w_v;
    logic             w_last;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (in_valid)  w_next_state = S_RUN;
            S_RUN:  if (w_last)    w_next_state = S_DONE;
            S_DONE: if (out_ready) w_next_state = S_IDLE;
            default:               w_next_state = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready    = (r_state == S_IDLE);
        out_valid   = (r_state == S_DONE);
        o_dbg_state = r_state;
    end

    // ---------------- digit datapath ----------------
    assign w_last = (r_state == S_RUN) && (r_count == CW'(K - 1));

    // Ripple of full-adder cells across one digit, fed by the running carry.
    always_comb begin
        w_chain    = '0;
        w_sum      = '0;
        w_chain[0] = r_carry;
        for (int i = 0; i < DIGIT; i++) begin
            w_sum[i]     = r_a_sh[i] ^ r_b_sh[i] ^ w_chain[i];
            w_chain[i+1] = (r_a_sh[i] & r_b_sh[i]) |
                           (w_chain[i] & (r_a_sh[i] ^ r_b_sh[i]));
        end
    end

    // New sum bits enter at the top so the LSB digit ends at bit 0 after K steps.
    assign w_res_next = (r_res >> DIGIT) | (WIDTH'(w_sum) << (WIDTH - DIGIT));

    // Overflow only when both addends share a sign that the result lacks.
    assign w_v     = (r_sign_a == r_sign_nb) && (w_res_next[WIDTH-1] != r_sign_a);
    assign w_sat   = r_sign_a ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    assign w_final = w_v ? w_sat : w_res_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sh    <= '0;
            r_b_sh    <= '0;
            r_res     <= '0;
            r_carry   <= 1'b1;
            r_count   <= '0;
            r_sign_a  <= 1'b0;
            r_sign_nb <= 1'b0;
            r_diff    <= '0;
            r_flag_n  <= 1'b0;
            r_flag_z  <= 1'b0;
            r_flag_v  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a_sh    <= A;
                        r_b_sh    <= ~B;
                        r_res     <= '0;
                        r_carry   <= 1'b1;
                        r_count   <= '0;
                        r_sign_a  <= A[WIDTH-1];
                        r_sign_nb <= ~B[WIDTH-1];
                    end
                end
                S_RUN: begin
                    r_a_sh  <= r_a_sh >> DIGIT;
                    r_b_sh  <= r_b_sh >> DIGIT;
                    r_res   <= w_res_next;
                    r_carry <= w_chain[DIGIT];
                    r_count <= r_count + CW'(1);
                    if (w_last) begin
                        r_diff   <= w_final;
                        r_flag_n <= w_final[WIDTH-1];
                        r_flag_z <= (w_final == '0);
                        r_flag_v <= w_v;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign Diff  = r_diff;
    assign FlagN = r_flag_n;
    assign FlagZ = r_flag_z;
    assign FlagV = r_flag_v;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed and random operands on a
// DIGIT=1 and a DIGIT=4 instance, checked against a signed-integer model.
module tb_serial_subtractor;

    logic        clk;
    logic        rst;
    logic        iv1, iv4;
    logic        out_ready;
    logic [15:0] a_in, b_in;
    logic        sel;

    logic        rdy1, ov1, n1, z1, v1;
    logic        rdy4, ov4, n4, z4, v4;
    logic [15:0] d1, d4;
    logic [1:0]  st1, st4;

    logic        m_in_ready, m_out_valid, m_n, m_z, m_v;
    logic [15:0] m_diff;
    logic [1:0]  m_state;

    int total = 0;
    int bad   = 0;

    logic [18:0] exp_q[$];

    serial_subtractor #(.WIDTH(16), .DIGIT(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(rdy1),
        .A(a_in), .B(b_in), .out_valid(ov1), .out_ready(out_ready),
        .Diff(d1), .FlagN(n1), .FlagZ(z1), .FlagV(v1), .o_dbg_state(st1)
    );

    serial_subtractor #(.WIDTH(16), .DIGIT(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(rdy4),
        .A(a_in), .B(b_in), .out_valid(ov4), .out_ready(out_ready),
        .Diff(d4), .FlagN(n4), .FlagZ(z4), .FlagV(v4), .o_dbg_state(st4)
    );

    assign m_in_ready  = sel ? rdy4 : rdy1;
    assign m_out_valid = sel ? ov4  : ov1;
    assign m_diff      = sel ? d4   : d1;
    assign m_n         = sel ? n4   : n1;
    assign m_z         = sel ? z4   : z1;
    assign m_v         = sel ? v4   : v1;
    assign m_state     = sel ? st4  : st1;

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model: {V, Z, N, Diff} ----------------
    function automatic logic [18:0] model(input logic [15:0] a, input logic [15:0] b);
        int          d;
        logic        v;
        logic [15:0] r;
        d = int'($signed(a)) - int'($signed(b));
        v = 1'b0;
        if (d > 32767) begin
            d = 32767;
            v = 1'b1;
        end else if (d < -32768) begin
            d = -32768;
            v = 1'b1;
        end
        r = d[15:0];
        return {v, (r == 16'h0000), r[15], r};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver + scoreboard ----------------
    task automatic run_op(input logic s, input logic [15:0] a, input logic [15:0] b,
                          input int hold);
        int          k;
        int          n;
        logic [18:0] exp_v;
        logic [18:0] got;
        k   = s ? 4 : 16;
        sel = s;
        exp_q.push_back(model(a, b));
        n = 0;
        while (!m_in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_wait", 32'(n < 50), 32'd1);
        a_in = a;
        b_in = b;
        if (s) iv4 = 1'b1; else iv1 = 1'b1;
        @(posedge clk); #1;
        iv1  = 1'b0;
        iv4  = 1'b0;
        a_in = 16'($urandom);
        b_in = 16'($urandom);
        chk("busy_in_ready", 32'(m_in_ready), 32'd0);
        n = 0;
        while (!m_out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("latency", n, k);
        exp_v = exp_q.pop_front();
        got   = {m_v, m_z, m_n, m_diff};
        chk("result", 32'(got), 32'(exp_v));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_stable", 32'({m_out_valid, m_in_ready, m_v, m_z, m_n, m_diff}),
                32'({1'b1, 1'b0, exp_v}));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("consumed", 32'({m_out_valid, m_in_ready}), 32'b01);
        chk("retained", 32'({m_v, m_z, m_n, m_diff}), 32'(exp_v));
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        rst       = 1'b1;
        iv1       = 1'b0;
        iv4       = 1'b0;
        out_ready = 1'b0;
        a_in      = '0;
        b_in      = '0;
        sel       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dut1", 32'({st1, rdy1, ov1, v1, z1, n1, d1}), 32'({2'd0, 1'b1, 1'b0, 19'd0}));
        chk("rst_dut4", 32'({st4, rdy4, ov4, v4, z4, n4, d4}), 32'({2'd0, 1'b1, 1'b0, 19'd0}));
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases on the bit-serial instance.
        run_op(1'b0, 16'h0005, 16'h0003, 0);
        chk("basic_diff", 32'(d1), 32'h0002);
        run_op(1'b0, 16'h0003, 16'h0005, 1);
        chk("neg_diff", 32'({n1, d1}), 32'h1FFFE);
        run_op(1'b0, 16'h8000, 16'h0001, 0);
        chk("neg_sat", 32'({v1, n1, d1}), 32'h38000);
        run_op(1'b0, 16'h7FFF, 16'hFFFF, 0);
        chk("pos_sat", 32'({v1, n1, d1}), 32'h27FFF);
        run_op(1'b0, 16'h1234, 16'h1234, 5);
        chk("zero_flag", 32'({z1, d1}), 32'h10000);

        // Digit-wide instance.
        run_op(1'b1, 16'h1000, 16'h0001, 2);
        chk("digit4_diff", 32'(d4), 32'h0FFF);

        // Reset during the second RUN cycle discards the operation.
        sel  = 1'b1;
        a_in = 16'h4321;
        b_in = 16'h0101;
        iv4  = 1'b1;
        @(posedge clk); #1;
        iv4 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #3;
        chk("rst_mid_state", 32'({st4, rdy4, ov4}), 32'({2'd0, 1'b1, 1'b0}));
        chk("rst_mid_diff", 32'({v4, z4, n4, d4}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("rst_no_valid", 32'({st4, ov4}), 32'd0);
        end
        run_op(1'b1, 16'h0010, 16'h0020, 0);

        // Random operands, mixing in boundary values.
        for (int i = 0; i < 24; i++) begin
            logic [15:0] ra, rb;
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ($urandom_range(0, 3) == 0) ra = ($urandom_range(0, 1) != 0) ? 16'h8000 : 16'h7FFF;
            if ($urandom_range(0, 3) == 0) rb = ($urandom_range(0, 1) != 0) ? 16'h8000 : 16'h0001;
            run_op(1'($urandom_range(0, 1)), ra, rb, $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Multi-cycle saturating subtractor. Computes Diff = A - B as A + ~B + 1, processing DIGIT bits per cycle from LSB to MSB.
- It is the inverse-direction arithmetic companion to the one-bit full-adder primitive.
- Used by the ALU for SUB and for the compare path where area matters more than latency.
- Produces the 16-bit two's-complement saturated result and the N/Z/V flags. Uses a valid/ready handshake on both sides.

Parameters:
- WIDTH, 16, operand and result width in bits. Must be a multiple of DIGIT.
- DIGIT, 1, bits processed per RUN cycle. Latency K = WIDTH/DIGIT.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  operands A/B valid.
- in_ready  output  1  block can accept operands (high only in IDLE).
- A  input  WIDTH  minuend, two's complement.
- B  input  WIDTH  subtrahend, two's complement.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer accepts result.
- Diff  output  WIDTH  saturated A - B.
- FlagN  output  1  Diff MSB.
- FlagZ  output  1  Diff == 0.
- FlagV  output  1  signed overflow occurred; Diff is saturated.

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, Diff=0, FlagN=0, FlagZ=0, FlagV=0, count=0, carry=1, operand/shift registers=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch A into a_sh and ~B into b_sh, set carry=1, count=0, go to RUN.
  - A and B are sampled only at this edge; later changes are ignored.
- RUN:
  - in_ready=0.
  - Each edge adds the low DIGIT bits of a_sh and b_sh plus carry, as a ripple of full-adder cells.
  - The DIGIT sum bits shift into the top of the result register, which shifts right by DIGIT; a_sh and b_sh also shift right by DIGIT.
  - carry takes the digit carry-out; count increments.
  - Keep the sign of the original A and of ~B (the latched MSBs) for the overflow check.
- Final RUN edge (count=K-1):
  - Compute the raw result R and V = (signA == sign(~B)) && (R MSB != signA).
  - If V=1: Diff = signA ? {1'b1,{WIDTH-1{0}}} : {1'b0,{WIDTH-1{1}}}. Otherwise Diff = R.
  - FlagN = Diff MSB, FlagZ = (Diff == 0), FlagV = V.
  - out_valid=1; go to DONE.
- Latency: out_valid rises K edges after the accepting edge (16 for the defaults).
- DONE:
  - in_ready=0.
  - Diff and flags are held stable while out_valid=1 and out_ready=0 (no glitching under backpressure).
  - On an edge with out_ready=1: out_valid=0, go to IDLE. Diff and flags keep their last values.
- No new operand is accepted in the same cycle a result is consumed. Minimum initiation interval is K+2 cycles.
- out_ready is ignored outside DONE. in_valid is ignored outside IDLE.
- Reset asserted mid-RUN or in DONE: immediate return to reset values. The in-flight operation is discarded and no out_valid pulse occurs.
- Carry-out of the MSB is not a port. The borrow is the inverted carry and is not exported.

Test Plan:
- Basic subtract: A=0x0005, B=0x0003, defaults -> out_valid exactly 16 cycles after accept; Diff=0x0002, N=0, Z=0, V=0.
- Negative result: A=0x0003, B=0x0005 -> Diff=0xFFFE, N=1, Z=0, V=0.
- Negative saturation: A=0x8000, B=0x0001 -> Diff=0x8000, N=1, V=1, Z=0.
- Positive saturation: A=0x7FFF, B=0xFFFF -> Diff=0x7FFF, V=1, N=0.
- Zero and backpressure: A=B=0x1234 -> Diff=0x0000, Z=1. Hold out_ready=0 for 5 cycles: Diff/flags stable and in_ready=0. Raise out_ready -> next cycle out_valid=0, in_ready=1.
- DIGIT=4 and reset: DIGIT=4 with A=0x1000, B=0x0001 -> Diff=0x0FFF after 4 cycles. Assert rst during cycle 2 of a run -> out_valid stays 0, state IDLE, and the next operation completes correctly.
